ttl74_bank: RTL
===============

// Module: ttl74_bank
// PURPOSE
//  Parametrised bank of WIDTH 74-family edge-triggered flip-flops for board-logic emulation
//  (7474 D-type, or 74109 J/K_n-type), all running on the single system clock.
//  Each channel has its own TTL clock net: rising edges are detected by sampling, not used as clocks.
//  Adds per-channel clear/preset with true both-low semantics, optional input synchronisers,
//  and a per-channel accepted-edge strobe.
// PARAMETERS
//  WIDTH        4      number of independent flip-flop channels (1..32)
//  MODE         0      0 = D-type (7474), 1 = J/K_n-type (74109); same for all channels
//  SYNC_STAGES  0      extra register stages on tclk/d/k_n/clear_n/preset_n (0..2)
//  INIT_Q       0      WIDTH-bit value loaded into q state on reset
// PORTS
//  clk        in   1      system clock; only clock in the block
//  reset      in   1      synchronous, active-high reset
//  tclk       in   WIDTH  per-channel TTL clock nets, sampled on clk
//  clear_n    in   WIDTH  per-channel clear, active low, level-sensitive
//  preset_n   in   WIDTH  per-channel preset, active low, level-sensitive
//  d          in   WIDTH  D input (MODE 0) / J input (MODE 1)
//  k_n        in   WIDTH  K_n input (MODE 1); ignored in MODE 0
//  q          out  WIDTH  registered Q
//  q_n        out  WIDTH  registered Q_n (not always ~q; see both-low)
//  tick       out  WIDTH  one-cycle strobe: clocked update applied this cycle
// BEHAVIOUR
//  - Reset (reset=1 at a clk edge): q=INIT_Q, q_n=~INIT_Q, tick=0, sync stages cleared,
//    tclk_prev=all-ones (tclk high out of reset gives no edge). Overrides every other input.
//  - Input path: tclk, d, k_n, clear_n, preset_n pass through SYNC_STAGES identical
//    registers so they stay mutually aligned (sync regs reset: tclk/clear_n/preset_n=1, d/k_n=0).
//  - Edge: edge[i] = tclk_s[i] & ~tclk_prev[i]; tclk_prev updates every cycle, even during
//    clear/preset. Latency input rise -> q update = SYNC_STAGES+1 clk edges.
//  - Priority per channel, evaluated each clk edge on synchronised values:
//    1. clear_n=0 & preset_n=0: q=1, q_n=1 (both high, as real part); state bit := 0.
//    2. clear_n=0: q=0, q_n=1.   3. preset_n=0: q=1, q_n=0.
//    4. edge: apply mode function, tick=1.   5. else hold, tick=0.
//  - Clocked function, MODE 0: q := d. MODE 1 (J,K_n): 00 -> 0; 01 -> hold; 10 -> toggle; 11 -> 1.
//  - Edge coincident with clear/preset: edge discarded, tick=0 (asynchronous input wins).
//  - Release of both-low: q/q_n return to state bit 0 / 1 on the next clk edge, no glitch
//    to preset value.
//  - q_n equals ~q at all times except during case 1.
//  - Channels fully independent; no cross-channel interaction; tick never stays high 2 cycles
//    for one tclk edge.
//  - Reset asserted mid-sequence: all pending edges dropped; first edge after reset needs tclk
//    to go low then high.
// STRUCTURE
//  - Shared package ttl_pkg: MODE_D=0, MODE_JK=1 constants; jk_next(q,j,k_n) function.
//  - One sub-module ttl_sync_delay (WIDTH-generic, SYNC_STAGES shift register with reset value
//    parameter) instantiated per input group; top uses a generate loop over channels.
//  - State held as q_state (WIDTH) plus both_low (WIDTH); q/q_n decoded from these, registered.
// TESTING
//  - Reset with INIT_Q=4'b1010, tclk=4'hF held -> q=1010, q_n=0101, tick=0 for 10 cycles.
//  - MODE 0, SYNC 0: d[0]=1, tclk[0] 0->1 at cycle 5 -> q[0]=1, tick[0]=1 at cycle 6 only.
//  - MODE 1: J=1,K_n=0, 4 tclk edges -> q toggles 1,0,1,0; J=0,K_n=1 edge -> hold, tick=1.
//  - clear_n=0 & preset_n=0 -> q=1,q_n=1; release together -> q=0,q_n=1; edge during
//    clear -> tick=0, q=0.
//  - SYNC_STAGES=2: tclk rise at cycle 10 -> q updates cycle 13; reset at cycle 11 -> no update.

Source files
------------

// File: rtl/ttl_pkg.sv
// Shared constants and helpers for the 74-family flip-flop bank.
// The J/K_n next-state function mirrors the 74109 truth table.
package ttl_pkg;

    localparam int MODE_D  = 0;
    localparam int MODE_JK = 1;

    localparam int MAX_WIDTH  = 32;
    localparam int MAX_STAGES = 2;

    // 74109: J and active-low K; {j,k_n}=10 toggles, 01 holds
    function automatic logic jk_next(
        input logic q,
        input logic j,
        input logic k_n
    );
        logic nxt;
        nxt = q;
        unique case ({j, k_n})
            2'b00:   nxt = 1'b0;
            2'b01:   nxt = q;
            2'b10:   nxt = ~q;
            2'b11:   nxt = 1'b1;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ttl74_bank_sync.sv
// Fixed-depth register chain used to align the TTL inputs.
// With zero stages the input passes straight through.
module ttl_sync_delay #(
    parameter int                 WIDTH   = 4,
    parameter int                 STAGES  = 0,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset};
            assign delayed = data;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < STAGES; s++) begin
                        stage[s] <= RST_VAL;
                    end
                end else begin
                    stage[0] <= data;
                    for (int s = 1; s < STAGES; s++) begin
                        stage[s] <= stage[s-1];
                    end
                end
            end

            assign delayed = stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ttl74_bank.sv
// Bank of 7474 / 74109 flip-flops emulated on one system clock.
// TTL clock nets are edge-detected by sampling, never used as clocks.
module ttl74_bank
    import ttl_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               MODE        = MODE_D,
    parameter int               SYNC_STAGES = 0,
    parameter logic [WIDTH-1:0] INIT_Q      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tclk,
    input  logic [WIDTH-1:0] clear_n,
    input  logic [WIDTH-1:0] preset_n,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] k_n,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] tick
);

    localparam logic [WIDTH-1:0] ONES  = '1;
    localparam logic [WIDTH-1:0] ZEROS = '0;

    logic [WIDTH-1:0] tclk_s;
    logic [WIDTH-1:0] clear_s;
    logic [WIDTH-1:0] preset_s;
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] k_n_s;

    logic [WIDTH-1:0] tclk_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] q_state;
    logic [WIDTH-1:0] both_low;

    logic [WIDTH-1:0] state_nxt;
    logic [WIDTH-1:0] low_nxt;
    logic [WIDTH-1:0] tick_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_n_nxt;

    // Every input group goes through the same depth so they stay aligned
    ttl_sync_delay #(
        .WIDTH(WIDTH), .STAGES(SYNC_STAGES), .RST_VAL(ONES)
    ) u_sync_tclk (
        .clk(clk), .reset(reset), .data(tclk), .delayed(tclk_s)
    );

    ttl_sync_delay #(
        .WIDTH(WIDTH), .STAGES(SYNC_STAGES), .RST_VAL(ONES)
    ) u_sync_clear (
        .clk(clk), .reset(reset), .data(clear_n), .delayed(clear_s)
    );

    ttl_sync_delay #(
        .WIDTH(WIDTH), .STAGES(SYNC_STAGES), .RST_VAL(ONES)
    ) u_sync_preset (
        .clk(clk), .reset(reset), .data(preset_n), .delayed(preset_s)
    );

    ttl_sync_delay #(
        .WIDTH(WIDTH), .STAGES(SYNC_STAGES), .RST_VAL(ZEROS)
    ) u_sync_d (
        .clk(clk), .reset(reset), .data(d), .delayed(d_s)
    );

    ttl_sync_delay #(
        .WIDTH(WIDTH), .STAGES(SYNC_STAGES), .RST_VAL(ZEROS)
    ) u_sync_k (
        .clk(clk), .reset(reset), .data(k_n), .delayed(k_n_s)
    );

    assign edge_det = tclk_s & ~tclk_prev;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            logic clr;
            logic pre;
            logic fn;

            assign clr = ~clear_s[i];
            assign pre = ~preset_s[i];

            if (MODE == MODE_JK) begin : g_jk
                assign fn = jk_next(q_state[i], d_s[i], k_n_s[i]);
            end else begin : g_d
                assign fn = d_s[i];
            end

            // Clear/preset win over a coincident edge; both-low parks state at 0
            assign low_nxt[i]   = clr & pre;
            assign state_nxt[i] = clr         ? 1'b0 :
                                  pre         ? 1'b1 :
                                  edge_det[i] ? fn   :
                                                q_state[i];
            assign tick_nxt[i]  = ~clr & ~pre & edge_det[i];
        end
    endgenerate

    logic unused_k;
    assign unused_k = ^k_n_s;

    assign q_nxt   = state_nxt | low_nxt;
    assign q_n_nxt = ~state_nxt | low_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            tclk_prev <= ONES;
            q_state   <= INIT_Q;
            both_low  <= ZEROS;
            q         <= INIT_Q;
            q_n       <= ~INIT_Q;
            tick      <= ZEROS;
        end else begin
            tclk_prev <= tclk_s;
            q_state   <= state_nxt;
            both_low  <= low_nxt;
            q         <= q_nxt;
            q_n       <= q_n_nxt;
            tick      <= tick_nxt;
        end
    end

endmodule
